// File: rtl/dpram_fifo_pkg.sv
// Shared constants and helpers for the dpram-backed FIFO controller.
package dpram_fifo_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH      = 2 ** ADDR_W_DEF;
    localparam int OBUF_DEPTH = 2;
    localparam int LEVEL_W    = ADDR_W_DEF + 2;

    // True while the memory still has room for one more word.
    function automatic logic mem_has_space(input int cnt, input int depth);
        return cnt < depth;
    endfunction

endpackage

// File: rtl/dpram_fifo_obuf.sv
// Two-entry first-word-fall-through output buffer. entry0 is always the head.
// A push and a pop in the same cycle are both honoured.
module dpram_fifo_obuf
    import dpram_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [1:0]        cnt,
    output logic [DATA_W-1:0] head_data,
    output logic              valid
);

    logic [DATA_W-1:0] entry0;
    logic [DATA_W-1:0] entry1;

    assign head_data = entry0;
    assign valid     = (cnt != 2'd0);

    // Entry storage and occupancy; flush drops everything including a same-cycle push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= 2'd0;
            entry0 <= '0;
            entry1 <= '0;
        end else if (flush) begin
            cnt    <= 2'd0;
            entry0 <= '0;
            entry1 <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) entry0 <= push_data;
                    else             entry1 <= push_data;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    cnt    <= cnt - 2'd1;
                end
                2'b11: begin
                    // Pop is only legal with cnt >= 1, so cnt stays the same.
                    if (cnt == 2'd1) begin
                        entry0 <= push_data;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller driving an external 1024x8 dual-port RAM. Keeps write/read
// pointers and the memory word count, issues one-cycle-latency reads into a
// two-entry output buffer, and reports total occupancy.
//
// Handshake: a word moves on a side in any cycle where valid and ready are
// both high at the rising edge; valid must not depend on ready, and in_ready
// depends only on registered state and flush.
module dpram_fifo_ctrl
    import dpram_fifo_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W+1:0] level,
    output logic [0:ADDR_W-1] mem_waddr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_data_in,
    output logic [0:ADDR_W-1] mem_raddr,
    output logic              mem_ren,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam int MEM_DEPTH = 2 ** ADDR_W;
    localparam int CNT_W     = ADDR_W + 1;
    localparam int LVL_W     = ADDR_W + 2;

    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [CNT_W-1:0]  mem_cnt;
    logic [CNT_W-1:0]  mem_cnt_next;
    logic              inflight;
    logic              running;
    logic [1:0]        ob_cnt;
    logic [1:0]        ob_cnt_next;
    logic [2:0]        ob_demand;
    logic [LVL_W-1:0]  level_next;
    logic              accept;
    logic              issue;
    logic              pop;
    logic              push;

    // Accept side: full comes from mem_cnt alone, never from pointer compare.
    assign in_ready = running & ~flush & mem_has_space(int'(mem_cnt), MEM_DEPTH);
    assign accept   = in_valid & in_ready;

    // Read side: a read is only issued when its returning word is sure to fit.
    assign pop       = out_valid & out_ready;
    assign push      = inflight;
    assign ob_demand = {1'b0, ob_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign issue     = running & ~flush & (mem_cnt != '0) & (ob_demand < 3'(OBUF_DEPTH));

    assign mem_wen     = accept;
    assign mem_waddr   = wptr;
    assign mem_data_in = in_data;
    assign mem_ren     = issue;
    assign mem_raddr   = rptr;

    // Next-state counts used for both the count registers and the level output.
    always_comb begin
        mem_cnt_next = mem_cnt;
        ob_cnt_next  = ob_cnt;
        if (flush) begin
            mem_cnt_next = '0;
            ob_cnt_next  = 2'd0;
        end else begin
            case ({accept, issue})
                2'b10:   mem_cnt_next = mem_cnt + CNT_W'(1);
                2'b01:   mem_cnt_next = mem_cnt - CNT_W'(1);
                default: mem_cnt_next = mem_cnt;
            endcase
            ob_cnt_next = ob_cnt + 2'(push) - 2'(pop);
        end
        level_next = LVL_W'(mem_cnt_next) + LVL_W'(issue) + LVL_W'(ob_cnt_next);
    end

    // Pointers, memory count, in-flight flag and registered level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            mem_cnt  <= '0;
            inflight <= 1'b0;
            running  <= 1'b0;
            level    <= '0;
        end else begin
            running <= 1'b1;
            level   <= level_next;
            mem_cnt <= mem_cnt_next;
            if (flush) begin
                wptr     <= '0;
                rptr     <= '0;
                inflight <= 1'b0;
            end else begin
                if (accept) wptr <= wptr + ADDR_W'(1);
                if (issue)  rptr <= rptr + ADDR_W'(1);
                inflight <= issue;
            end
        end
    end

    dpram_fifo_obuf #(
        .DATA_W(DATA_W)
    ) u_obuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .push     (push),
        .push_data(mem_data_out),
        .pop      (pop),
        .cnt      (ob_cnt),
        .head_data(out_data),
        .valid    (out_valid)
    );

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl with a behavioural 1024x8 dual-port RAM model.
module tb_dpram_fifo_ctrl;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W+1:0] level;
    logic [0:ADDR_W-1] mem_waddr;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_data_in;
    logic [0:ADDR_W-1] mem_raddr;
    logic              mem_ren;
    logic [DATA_W-1:0] mem_data_out;

    int pass_cnt = 0;
    int check_cnt = 0;

    logic [DATA_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    dpram_fifo_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .level       (level),
        .mem_waddr   (mem_waddr),
        .mem_wen     (mem_wen),
        .mem_data_in (mem_data_in),
        .mem_raddr   (mem_raddr),
        .mem_ren     (mem_ren),
        .mem_data_out(mem_data_out)
    );

    // Behavioural dpram_1024x8: write commits at the edge, read data one cycle after ren.
    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];
    always @(posedge clk) begin
        if (mem_wen) mem[mem_waddr] <= mem_data_in;
        if (mem_ren) mem_data_out <= mem[mem_raddr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_cnt++;
        if (out_valid !== 1'b0 || level !== '0 || mem_wen !== 1'b0 || mem_ren !== 1'b0)
            $display("FAIL reset_outputs: out_valid=%0b level=%0d wen=%0b ren=%0b, required all 0",
                     out_valid, level, mem_wen, mem_ren);
        else pass_cnt++;
        check_cnt++;
        if (mem_waddr !== '0 || mem_raddr !== '0 || out_data !== '0)
            $display("FAIL reset_addr: waddr=%0d raddr=%0d out_data=%h, required 0", mem_waddr, mem_raddr, out_data);
        else pass_cnt++;
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        check_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b, required 1", in_ready);
        else pass_cnt++;
    endtask

    task automatic test_single();
        tick();
        in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
        @(negedge clk);
        check_cnt++;
        if (mem_wen !== 1'b1 || mem_waddr !== '0 || mem_data_in !== 8'hA5)
            $display("FAIL single_write: wen=%0b waddr=%0d din=%h, required 1/0/a5", mem_wen, mem_waddr, mem_data_in);
        else pass_cnt++;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check_cnt++;
        if (mem_ren !== 1'b1 || mem_raddr !== '0 || level !== 12'd1)
            $display("FAIL single_issue: ren=%0b raddr=%0d level=%0d, required 1/0/1", mem_ren, mem_raddr, level);
        else pass_cnt++;
        tick();
        @(negedge clk);
        check_cnt++;
        if (out_valid !== 1'b0) $display("FAIL single_early: out_valid=%0b, required 0", out_valid);
        else pass_cnt++;
        tick();
        @(negedge clk);
        check_cnt++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || level !== 12'd1)
            $display("FAIL single_out: out_valid=%0b data=%h level=%0d, required 1/a5/1", out_valid, out_data, level);
        else pass_cnt++;
        tick();
        @(negedge clk);
        check_cnt++;
        if (out_valid !== 1'b0 || level !== '0)
            $display("FAIL single_after_pop: out_valid=%0b level=%0d, required 0/0", out_valid, level);
        else pass_cnt++;
    endtask

    task automatic test_fill();
        int sent;
        int recv;
        sent = 0;
        tick();
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 1200; c++) begin
            in_data = sent[7:0];
            @(negedge clk);
            if (!in_ready) break;
            sent++;
            tick();
        end
        in_valid = 1'b0;
        check_cnt++;
        if (sent != 1026) $display("FAIL fill_accepts: got %0d, required 1026", sent);
        else pass_cnt++;
        check_cnt++;
        if (level !== 12'd1026 || in_ready !== 1'b0)
            $display("FAIL fill_level: level=%0d in_ready=%0b, required 1026/0", level, in_ready);
        else pass_cnt++;
        check_cnt++;
        if (out_valid !== 1'b1 || out_data !== 8'h00)
            $display("FAIL fill_head: out_valid=%0b data=%h, required 1/00", out_valid, out_data);
        else pass_cnt++;
        tick();
        out_ready = 1'b1;
        recv = 0;
        for (int c = 0; c < 1300 && recv < 1026; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check_cnt++;
                if (in_ready !== 1'b1) $display("FAIL fill_reopen: in_ready=%0b, required 1", in_ready);
                else pass_cnt++;
            end
            if (out_valid) begin
                check_cnt++;
                if (out_data !== recv[7:0])
                    $display("FAIL fill_order: word %0d got %h, required %h", recv, out_data, recv[7:0]);
                else pass_cnt++;
                recv++;
            end
            tick();
        end
        out_ready = 1'b0;
        check_cnt++;
        if (recv != 1026) $display("FAIL fill_drain_count: got %0d, required 1026", recv);
        else pass_cnt++;
        @(negedge clk);
        check_cnt++;
        if (out_valid !== 1'b0 || level !== '0)
            $display("FAIL fill_empty: out_valid=%0b level=%0d, required 0/0", out_valid, level);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int sent;
        int recv;
        int gaps;
        int wwrap;
        int rwrap;
        logic [7:0] exp;
        sent = 0; recv = 0; gaps = 0; wwrap = 0; rwrap = 0;
        tick();
        in_valid = 1'b1; out_ready = 1'b1; in_data = 8'(0) ^ 8'h5A;
        for (int c = 0; c < 3300 && recv < 3000; c++) begin
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            if (mem_wen && mem_waddr == 10'd1023) wwrap++;
            if (mem_ren && mem_raddr == 10'd1023) rwrap++;
            if (out_valid) begin
                exp = 8'(recv * 3) ^ 8'h5A;
                check_cnt++;
                if (out_data !== exp) $display("FAIL b2b_order: word %0d got %h, required %h", recv, out_data, exp);
                else pass_cnt++;
                recv++;
            end else if (recv > 0 && recv < 3000) begin
                gaps++;
            end
            tick();
            in_valid = (sent < 3000);
            in_data = 8'(sent * 3) ^ 8'h5A;
        end
        in_valid = 1'b0;
        check_cnt++;
        if (recv != 3000 || sent != 3000) $display("FAIL b2b_count: sent=%0d recv=%0d, required 3000/3000", sent, recv);
        else pass_cnt++;
        check_cnt++;
        if (gaps != 0) $display("FAIL b2b_gaps: got %0d bubbles, required 0", gaps);
        else pass_cnt++;
        check_cnt++;
        if (wwrap < 2 || rwrap < 2) $display("FAIL b2b_wrap: wwrap=%0d rwrap=%0d, required >=2 each", wwrap, rwrap);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int model_cnt;
        logic prev_stall;
        logic [7:0] prev_data;
        model_cnt = 0; prev_stall = 1'b0; prev_data = '0;
        exp_q.delete();
        tick();
        for (int c = 0; c < 10000; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data = 8'($urandom_range(0, 255));
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_cnt++;
            if (level !== 12'(model_cnt)) $display("FAIL bp_level: cycle %0d got %0d, required %0d", c, level, model_cnt);
            else pass_cnt++;
            if (prev_stall) begin
                check_cnt++;
                if (out_valid !== 1'b1 || out_data !== prev_data)
                    $display("FAIL bp_stable: cycle %0d valid=%0b data=%h, required 1/%h", c, out_valid, out_data, prev_data);
                else pass_cnt++;
            end
            if (out_valid) begin
                check_cnt++;
                if (exp_q.size() == 0) $display("FAIL bp_spurious: cycle %0d got %h, required no word", c, out_data);
                else if (out_data !== exp_q[0]) $display("FAIL bp_data: cycle %0d got %h, required %h", c, out_data, exp_q[0]);
                else pass_cnt++;
                if (out_ready && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    model_cnt--;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                model_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 2000 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            if (out_valid) begin
                check_cnt++;
                if (out_data !== exp_q[0]) $display("FAIL bp_drain: got %h, required %h", out_data, exp_q[0]);
                else pass_cnt++;
                void'(exp_q.pop_front());
            end
            tick();
        end
        out_ready = 1'b0;
        @(negedge clk);
        check_cnt++;
        if (exp_q.size() != 0 || level !== '0)
            $display("FAIL bp_final: left=%0d level=%0d, required 0/0", exp_q.size(), level);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        int pushed;
        logic seen;
        pushed = 0;
        tick();
        out_ready = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 20 && pushed < 5; c++) begin
            in_data = 8'h10 + 8'(pushed);
            @(negedge clk);
            if (in_ready) pushed++;
            tick();
            if (pushed == 5) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        repeat (4) tick();
        out_ready = 1'b1;
        @(negedge clk);
        check_cnt++;
        if (mem_ren !== 1'b1 || out_data !== 8'h10 || level !== 12'd5)
            $display("FAIL flush_setup: ren=%0b data=%h level=%0d, required 1/10/5", mem_ren, out_data, level);
        else pass_cnt++;
        tick();
        out_ready = 1'b0; flush = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
        @(negedge clk);
        check_cnt++;
        if (in_ready !== 1'b0 || mem_wen !== 1'b0 || mem_ren !== 1'b0)
            $display("FAIL flush_cycle: in_ready=%0b wen=%0b ren=%0b, required 0/0/0", in_ready, mem_wen, mem_ren);
        else pass_cnt++;
        check_cnt++;
        if (out_valid !== 1'b1 || out_data !== 8'h11)
            $display("FAIL flush_hold: out_valid=%0b data=%h, required 1/11", out_valid, out_data);
        else pass_cnt++;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_cnt++;
        if (out_valid !== 1'b0 || level !== '0)
            $display("FAIL flush_after: out_valid=%0b level=%0d, required 0/0", out_valid, level);
        else pass_cnt++;
        tick();
        in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                check_cnt++;
                if (out_data !== 8'h3C) $display("FAIL flush_first_word: got %h, required 3c", out_data);
                else pass_cnt++;
            end
            tick();
        end
        check_cnt++;
        if (!seen) $display("FAIL flush_timeout: out_valid=0, required 1 within 10 cycles");
        else pass_cnt++;
        @(negedge clk);
        check_cnt++;
        if (out_valid !== 1'b0 || level !== '0)
            $display("FAIL flush_drained: out_valid=%0b level=%0d, required 0/0", out_valid, level);
        else pass_cnt++;
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        logic seen;
        tick();
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_data = 8'h80 + 8'(i);
            tick();
        end
        @(negedge clk);
        check_cnt++;
        if (mem_wen !== 1'b1 || mem_ren !== 1'b1 || out_valid !== 1'b1 || level === '0)
            $display("FAIL areset_pre: wen=%0b ren=%0b valid=%0b level=%0d, required 1/1/1/nonzero",
                     mem_wen, mem_ren, out_valid, level);
        else pass_cnt++;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_cnt++;
        if (mem_wen !== 1'b0 || mem_ren !== 1'b0 || out_valid !== 1'b0 || level !== '0)
            $display("FAIL areset_drop: wen=%0b ren=%0b valid=%0b level=%0d, required all 0",
                     mem_wen, mem_ren, out_valid, level);
        else pass_cnt++;
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        check_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || level !== '0)
            $display("FAIL areset_release: in_ready=%0b valid=%0b level=%0d, required 1/0/0", in_ready, out_valid, level);
        else pass_cnt++;
        tick();
        in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                check_cnt++;
                if (out_data !== 8'h77) $display("FAIL areset_word: got %h, required 77", out_data);
                else pass_cnt++;
            end
            tick();
        end
        check_cnt++;
        if (!seen) $display("FAIL areset_timeout: out_valid=0, required 1 within 10 cycles");
        else pass_cnt++;
        out_ready = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at 2ms, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
